// File: rtl/iso14443_pkg.sv
// Shared ISO/IEC 14443 Type A encoding types and the quarter-bit modulation table,
// used by the frame encoders and the decoders.
package iso14443_pkg;

  typedef enum logic {
    MILLER     = 1'b0,
    MANCHESTER = 1'b1
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_PARITY,
    ST_EOF0,
    ST_EOF1,
    ST_FIN
  } enc_state_t;

  typedef enum logic [2:0] {
    SYM_X,
    SYM_Y,
    SYM_Z,
    SYM_D,
    SYM_E,
    SYM_F
  } symbol_t;

  // Modulation bit for quarter q of a symbol; 1 means carrier pause / load modulation.
  function automatic logic sym_pattern(input symbol_t sym, input logic [1:0] q);
    logic m;
    unique case (sym)
      SYM_X:   m = (q == 2'd2);
      SYM_Z:   m = (q == 2'd0);
      SYM_D:   m = ~q[1];
      SYM_E:   m = q[1];
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/iso14443_frame_encoder.sv
// Serialises a frame LSB first into modified Miller or Manchester quarter-bit
// modulation envelopes, with optional odd parity, abort and length-error reporting.
module iso14443_frame_encoder
  import iso14443_pkg::*;
#(
  parameter int MAX_BYTES = 8,
  localparam int NB_W = $clog2(8 * MAX_BYTES + 1)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   tick_in,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   mode_in,
  input  logic                   parity_en,
  input  logic [NB_W-1:0]        num_bits,
  input  logic [8*MAX_BYTES-1:0] data_in,
  input  logic                   abort_in,
  output logic                   mod_out,
  output logic                   busy_out,
  output logic                   done_out,
  output logic                   err_out
);

  localparam int FRAME_BITS = 8 * MAX_BYTES;
  localparam int IDX_W      = $clog2(FRAME_BITS);

  enc_state_t            state_q;
  symbol_t               sym_q;
  mode_t                 mode_q;
  logic                  parity_en_q;
  logic [NB_W-1:0]       nbits_q;
  logic [FRAME_BITS-1:0] data_q;
  logic [1:0]            q_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic [2:0]            byte_bit_q;
  logic                  par_acc_q;
  logic                  mod_q;
  logic                  done_q;
  logic                  err_q;

  logic [IDX_W-1:0] nxt_idx;
  logic             cur_bit;
  logic             nxt_bit;
  logic             last_bit;
  logic             byte_end;
  logic             illegal_len;
  enc_state_t       adv_state;
  logic             adv_val;
  symbol_t          adv_sym;

  assign nxt_idx     = (state_q == ST_SOF) ? '0 : bit_idx_q + IDX_W'(1);
  assign cur_bit     = data_q[bit_idx_q];
  assign nxt_bit     = data_q[nxt_idx];
  assign last_bit    = ((NB_W'(bit_idx_q) + NB_W'(1)) == nbits_q);
  assign byte_end    = parity_en_q && (byte_bit_q == 3'd7);
  assign illegal_len = (num_bits == '0) || (num_bits > NB_W'(FRAME_BITS));

  // Symbol that follows the one currently being presented, decided at its q == 3.
  always_comb begin
    adv_state = ST_FIN;
    adv_val   = 1'b0;
    unique case (state_q)
      ST_SOF: begin
        adv_state = ST_DATA;
        adv_val   = nxt_bit;
      end
      ST_DATA: begin
        if (byte_end) begin
          adv_state = ST_PARITY;
          adv_val   = ~(par_acc_q ^ cur_bit);
        end else if (last_bit) begin
          adv_state = ST_EOF0;
        end else begin
          adv_state = ST_DATA;
          adv_val   = nxt_bit;
        end
      end
      ST_PARITY: begin
        if (last_bit) begin
          adv_state = ST_EOF0;
        end else begin
          adv_state = ST_DATA;
          adv_val   = nxt_bit;
        end
      end
      ST_EOF0: adv_state = (mode_q == MILLER) ? ST_EOF1 : ST_FIN;
      default: adv_state = ST_FIN;
    endcase

    if (adv_state == ST_EOF1) begin
      adv_sym = SYM_Y;
    end else if (mode_q == MANCHESTER) begin
      if (adv_state == ST_EOF0) adv_sym = SYM_F;
      else                      adv_sym = adv_val ? SYM_D : SYM_E;
    end else if (adv_val) begin
      adv_sym = SYM_X;
    end else begin
      adv_sym = (sym_q == SYM_X) ? SYM_Y : SYM_Z;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      sym_q       <= SYM_Y;
      mode_q      <= MILLER;
      parity_en_q <= 1'b0;
      nbits_q     <= '0;
      q_q         <= 2'd0;
      bit_idx_q   <= '0;
      byte_bit_q  <= 3'd0;
      par_acc_q   <= 1'b0;
      mod_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (req_valid) begin
          mode_q      <= mode_t'(mode_in);
          parity_en_q <= parity_en;
          nbits_q     <= num_bits;
          q_q         <= 2'd0;
          bit_idx_q   <= '0;
          byte_bit_q  <= 3'd0;
          par_acc_q   <= 1'b0;
          if (illegal_len) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            state_q <= ST_SOF;
            sym_q   <= mode_in ? SYM_D : SYM_Z;
          end
        end
      end else if (abort_in) begin
        state_q <= ST_IDLE;
        mod_q   <= 1'b0;
      end else if (tick_in) begin
        if (state_q == ST_FIN) begin
          mod_q   <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end else begin
          mod_q <= sym_pattern(sym_q, q_q);
          q_q   <= q_q + 2'd1;
          if (q_q == 2'd3) begin
            state_q <= adv_state;
            sym_q   <= adv_sym;
            if (state_q == ST_DATA) begin
              par_acc_q  <= (byte_bit_q == 3'd7) ? 1'b0 : (par_acc_q ^ cur_bit);
              byte_bit_q <= byte_bit_q + 3'd1;
            end
            if (adv_state == ST_DATA && state_q != ST_SOF) begin
              bit_idx_q <= nxt_idx;
            end
          end
        end
      end
    end
  end

  // Payload is only meaningful while busy, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (req_valid && req_ready) begin
      data_q <= data_in;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy_out  = (state_q != ST_IDLE);
  assign mod_out   = mod_q;
  assign done_out  = done_q;
  assign err_out   = err_q;

endmodule
